// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle logic/arith/shift ops plus a multi-cycle
// signed Booth multiplier and signed restoring divider sharing one FSM.
// Single-cycle results land in Rc on the start edge. Mul/div results land
// after WIDTH iterations.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   Ra,
  input  logic [WIDTH-1:0]   Rb,
  output logic [2*WIDTH-1:0] Rc,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_SHRA = 5'b10010;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control and output registers
  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic               is_mul_r;
  logic [2*WIDTH-1:0] rc_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;

  // Booth multiplier state: accumulator carries one guard bit so that
  // subtracting the most negative multiplicand cannot overflow.
  logic [WIDTH:0]     bth_acc_r;
  logic [WIDTH:0]     bth_mcand_r;
  logic [WIDTH-1:0]   bth_mplier_r;
  logic               bth_prev_r;

  // Restoring divider state, operating on magnitudes
  logic [WIDTH-1:0]   div_rem_r;
  logic [WIDTH-1:0]   div_quo_r;
  logic [WIDTH-1:0]   div_dvs_r;
  logic               div_negq_r;
  logic               div_negr_r;

  // Combinational helpers
  logic [SHW-1:0]     amt_s;
  logic [SHW-1:0]     amt_inv_s;
  logic [WIDTH-1:0]   single_res_s;
  logic               is_mul_op_s;
  logic               is_div_op_s;
  logic               rb_zero_s;
  logic [WIDTH-1:0]   abs_ra_s;
  logic [WIDTH-1:0]   abs_rb_s;

  logic [WIDTH:0]     bth_sum_s;
  logic [WIDTH:0]     bth_acc_nxt_s;
  logic [WIDTH-1:0]   bth_mplier_nxt_s;
  logic               bth_prev_nxt_s;
  logic [2*WIDTH-1:0] bth_prod_s;

  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic [WIDTH-1:0]   div_rem_nxt_s;
  logic [WIDTH-1:0]   div_quo_nxt_s;
  logic [WIDTH-1:0]   div_rem_fix_s;
  logic [WIDTH-1:0]   div_quo_fix_s;

  assign Rc          = rc_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

  // Decode the request and form the single-cycle result from live inputs
  always_comb begin
    amt_s        = Rb[SHW-1:0];
    // Opposite-direction amount for rotates; zero amount maps to zero.
    amt_inv_s    = {SHW{1'b0}} - amt_s;
    is_mul_op_s  = (opcode == OP_MUL);
    is_div_op_s  = (opcode == OP_DIV);
    rb_zero_s    = (Rb == {WIDTH{1'b0}});
    abs_ra_s     = Ra[WIDTH-1] ? ({WIDTH{1'b0}} - Ra) : Ra;
    abs_rb_s     = Rb[WIDTH-1] ? ({WIDTH{1'b0}} - Rb) : Rb;
    single_res_s = {WIDTH{1'b0}};
    case (opcode)
      OP_ADD:  single_res_s = Ra + Rb;
      OP_SUB:  single_res_s = Ra - Rb;
      OP_SHR:  single_res_s = Ra >> amt_s;
      OP_SHL:  single_res_s = Ra << amt_s;
      OP_ROR:  single_res_s = (Ra >> amt_s) | (Ra << amt_inv_s);
      OP_ROL:  single_res_s = (Ra << amt_s) | (Ra >> amt_inv_s);
      OP_AND:  single_res_s = Ra & Rb;
      OP_OR:   single_res_s = Ra | Rb;
      OP_NEG:  single_res_s = {WIDTH{1'b0}} - Ra;
      OP_NOT:  single_res_s = ~Ra;
      OP_SHRA: single_res_s = $signed(Ra) >>> amt_s;
      // Only reached on the divide-by-zero path: quotient is all ones.
      OP_DIV:  single_res_s = {WIDTH{1'b1}};
      default: single_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One radix-2 Booth step: add/subtract multiplicand, then arithmetic shift
  always_comb begin
    case ({bth_mplier_r[0], bth_prev_r})
      2'b01:   bth_sum_s = bth_acc_r + bth_mcand_r;
      2'b10:   bth_sum_s = bth_acc_r - bth_mcand_r;
      default: bth_sum_s = bth_acc_r;
    endcase
    bth_acc_nxt_s    = {bth_sum_s[WIDTH], bth_sum_s[WIDTH:1]};
    bth_mplier_nxt_s = {bth_sum_s[0], bth_mplier_r[WIDTH-1:1]};
    bth_prev_nxt_s   = bth_mplier_r[0];
    bth_prod_s       = {bth_acc_nxt_s[WIDTH-1:0], bth_mplier_nxt_s};
  end

  // One restoring-division step on magnitudes, plus final sign fix-up
  always_comb begin
    div_shift_s = {div_rem_r, div_quo_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, div_dvs_r};
    if (div_trial_s[WIDTH]) begin
      div_rem_nxt_s = div_shift_s[WIDTH-1:0];
    end else begin
      div_rem_nxt_s = div_trial_s[WIDTH-1:0];
    end
    div_quo_nxt_s = {div_quo_r[WIDTH-2:0], ~div_trial_s[WIDTH]};
    if (div_negq_r) begin
      div_quo_fix_s = {WIDTH{1'b0}} - div_quo_nxt_s;
    end else begin
      div_quo_fix_s = div_quo_nxt_s;
    end
    if (div_negr_r) begin
      div_rem_fix_s = {WIDTH{1'b0}} - div_rem_nxt_s;
    end else begin
      div_rem_fix_s = div_rem_nxt_s;
    end
  end

  // Control FSM with registered outputs and datapath iteration registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      is_mul_r     <= 1'b0;
      rc_r         <= {(2*WIDTH){1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      dbz_r        <= 1'b0;
      bth_acc_r    <= {(WIDTH+1){1'b0}};
      bth_mcand_r  <= {(WIDTH+1){1'b0}};
      bth_mplier_r <= {WIDTH{1'b0}};
      bth_prev_r   <= 1'b0;
      div_rem_r    <= {WIDTH{1'b0}};
      div_quo_r    <= {WIDTH{1'b0}};
      div_dvs_r    <= {WIDTH{1'b0}};
      div_negq_r   <= 1'b0;
      div_negr_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          dbz_r  <= 1'b0;
          if (start) begin
            busy_r <= 1'b1;
            cnt_r  <= {CW{1'b0}};
            if (is_mul_op_s) begin
              state_r      <= CALC;
              is_mul_r     <= 1'b1;
              bth_acc_r    <= {(WIDTH+1){1'b0}};
              bth_mcand_r  <= {Rb[WIDTH-1], Rb};
              bth_mplier_r <= Ra;
              bth_prev_r   <= 1'b0;
            end else if (is_div_op_s && !rb_zero_s) begin
              state_r    <= CALC;
              is_mul_r   <= 1'b0;
              div_rem_r  <= {WIDTH{1'b0}};
              div_quo_r  <= abs_ra_s;
              div_dvs_r  <= abs_rb_s;
              div_negq_r <= Ra[WIDTH-1] ^ Rb[WIDTH-1];
              div_negr_r <= Ra[WIDTH-1];
            end else begin
              // Single-cycle path, including divide by zero
              state_r <= DONE;
              done_r  <= 1'b1;
              dbz_r   <= is_div_op_s;
              rc_r    <= {(is_div_op_s ? Ra : {WIDTH{1'b0}}), single_res_s};
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        CALC: begin
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (is_mul_r) begin
            bth_acc_r    <= bth_acc_nxt_s;
            bth_mplier_r <= bth_mplier_nxt_s;
            bth_prev_r   <= bth_prev_nxt_s;
          end else begin
            div_rem_r <= div_rem_nxt_s;
            div_quo_r <= div_quo_nxt_s;
          end
          if (cnt_r == LAST) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            if (is_mul_r) begin
              rc_r <= bth_prod_s;
            end else begin
              rc_r <= {div_rem_fix_s, div_quo_fix_s};
            end
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          dbz_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          dbz_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH = 32): directed vector table,
// hand-written start/clear corner cases, and randomized ops against a model.
module tb_multicycle_alu;

  localparam int W = 32;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_SHRA = 5'b10010;

  logic           clock = 1'b0;
  logic           clear;
  logic           start;
  logic [4:0]     opcode;
  logic [W-1:0]   Ra;
  logic [W-1:0]   Rb;
  logic [2*W-1:0] Rc;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] rc;
    int          lat;
    logic        dbz;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  multicycle_alu #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .opcode      (opcode),
    .Ra          (Ra),
    .Rb          (Rb),
    .Rc          (Rc),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] rc, output int lat, output logic dbz);
    int          ia, ib;
    longint      la, lb, q, r;
    logic [63:0] pv, qv, rv;
    logic [4:0]  amt;
    logic [31:0] res;
    ia = a; ib = b; la = ia; lb = ib;
    amt = b[4:0];
    res = 32'h0; lat = 0; dbz = 1'b0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SHR:  res = a >> amt;
      OP_SHL:  res = a << amt;
      OP_ROR:  for (int i = 0; i < 32; i++) res[i] = a[(i + int'(amt)) % 32];
      OP_ROL:  for (int i = 0; i < 32; i++) res[(i + int'(amt)) % 32] = a[i];
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NEG:  res = -a;
      OP_NOT:  res = ~a;
      OP_SHRA: res = ia >>> amt;
      default: res = 32'h0;
    endcase
    rc = {32'h0, res};
    if (op == OP_MUL) begin
      pv  = la * lb;
      rc  = pv;
      lat = 32;
    end else if (op == OP_DIV) begin
      if (b == 32'h0) begin
        rc  = {a, 32'hFFFFFFFF};
        dbz = 1'b1;
      end else begin
        q   = la / lb;
        r   = la % lb;
        qv  = q;
        rv  = r;
        rc  = {rv[31:0], qv[31:0]};
        lat = 32;
      end
    end
  endfunction

  // Issue one op and wait (bounded) for done. mode 0: quiet inputs,
  // 1: random junk on inputs/start while busy, 2: start pulse at cycle 5.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mode, output logic [63:0] rc, output int lat,
                        output logic dbz, output logic ok);
    ok = 1'b1;
    opcode = op; Ra = a; Rb = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1 || div_by_zero !== 1'b0) ok = 1'b0;
      if (mode == 1) begin
        opcode = 5'($urandom); Ra = $urandom; Rb = $urandom; start = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        start = (lat == 4);
        opcode = OP_ADD; Ra = 32'h1; Rb = 32'h1;
      end
      @(posedge clock); #1;
      lat++;
    end
    rc  = Rc;
    dbz = div_by_zero;
    if (busy !== 1'b1) ok = 1'b0;
    if (mode != 0) start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("done_pulse", {63'h0, done}, 64'h0);
    chk("busy_after", {63'h0, busy}, 64'h0);
    chk("dbz_after", {63'h0, div_by_zero}, 64'h0);
    chk("rc_hold", Rc, rc);
  endtask

  initial begin
    logic [63:0] rc, erc;
    int          lat, elat;
    logic        dbz, edbz, ok, seen;
    logic [4:0]  ops [16];
    logic [4:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{OP_ADD,  32'hFFFFFFF5, 32'h00000002, 64'h00000000_FFFFFFF7, 0,  1'b0};
    vecs[1]  = '{OP_SHRA, 32'hFFFFFFF5, 32'h00000002, 64'h00000000_FFFFFFFD, 0,  1'b0};
    vecs[2]  = '{OP_ROR,  32'hFFFFFFF5, 32'h00000002, 64'h00000000_7FFFFFFD, 0,  1'b0};
    vecs[3]  = '{OP_MUL,  32'hFFFFFFF5, 32'h00000002, 64'hFFFFFFFF_FFFFFFEA, 32, 1'b0};
    vecs[4]  = '{OP_DIV,  32'hFFFFFFF5, 32'h00000002, 64'hFFFFFFFF_FFFFFFFB, 32, 1'b0};
    vecs[5]  = '{OP_DIV,  32'hFFFFFFF5, 32'h00000000, 64'hFFFFFFF5_FFFFFFFF, 0,  1'b1};
    vecs[6]  = '{OP_SUB,  32'h00000005, 32'h00000007, 64'h00000000_FFFFFFFE, 0,  1'b0};
    vecs[7]  = '{OP_SHR,  32'h80000001, 32'h00000021, 64'h00000000_40000000, 0,  1'b0};
    vecs[8]  = '{OP_SHL,  32'h80000001, 32'h00000004, 64'h00000000_00000010, 0,  1'b0};
    vecs[9]  = '{OP_ROL,  32'h80000001, 32'h00000001, 64'h00000000_00000003, 0,  1'b0};
    vecs[10] = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 64'h00000000_00F000F0, 0,  1'b0};
    vecs[11] = '{OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 64'h00000000_FFF0FFF0, 0,  1'b0};
    vecs[12] = '{OP_NEG,  32'h00000001, 32'h12345678, 64'h00000000_FFFFFFFF, 0,  1'b0};
    vecs[13] = '{OP_NOT,  32'h12345678, 32'h00000000, 64'h00000000_EDCBA987, 0,  1'b0};
    vecs[14] = '{5'b11111, 32'h12345678, 32'h00000003, 64'h00000000_00000000, 0, 1'b0};
    vecs[15] = '{OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 32, 1'b0};
    vecs[16] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 32, 1'b0};
    vecs[17] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 32, 1'b0};
    vecs[18] = '{OP_MUL,  32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 32, 1'b0};
    vecs[19] = '{OP_ROR,  32'h12345678, 32'h00000020, 64'h00000000_12345678, 0,  1'b0};

    ops = '{OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
            OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_SHRA, 5'b00000, 5'b11111, 5'b01011};

    clear = 1'b0; start = 1'b0; opcode = 5'h0; Ra = 32'h0; Rb = 32'h0;
    #12;
    chk("rst_rc", Rc, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_dbz", {63'h0, div_by_zero}, 64'h0);
    clear = 1'b1;
    @(posedge clock); #1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, rc, lat, dbz, ok);
      chk($sformatf("vec%0d_rc", i), rc, vecs[i].rc);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_dbz", i), {63'h0, dbz}, {63'h0, vecs[i].dbz});
      chk($sformatf("vec%0d_busy", i), {63'h0, ok}, 64'h1);
    end

    // Start pulsed at cycle 5 of a mul, and again in its done cycle
    run_op(OP_MUL, 32'hFFFFFFF5, 32'h00000002, 2, rc, lat, dbz, ok);
    chk("mulpulse_rc", rc, 64'hFFFFFFFF_FFFFFFEA);
    chk("mulpulse_lat", 64'(lat), 64'd32);
    chk("mulpulse_busy", {63'h0, ok}, 64'h1);

    // Clear mid-way through a second mul aborts it
    opcode = OP_MUL; Ra = 32'h00012345; Rb = 32'h00000777; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    clear = 1'b0;
    #1;
    chk("clr_rc", Rc, 64'h0);
    chk("clr_busy", {63'h0, busy}, 64'h0);
    chk("clr_done", {63'h0, done}, 64'h0);
    chk("clr_dbz", {63'h0, div_by_zero}, 64'h0);
    @(posedge clock); #1;
    clear = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("clr_no_done", {63'h0, seen}, 64'h0);
    run_op(OP_ADD, 32'hFFFFFFF5, 32'h00000002, 0, rc, lat, dbz, ok);
    chk("post_clr_add_rc", rc, 64'h00000000_FFFFFFF7);
    chk("post_clr_add_lat", 64'(lat), 64'd0);

    // Randomized ops with junk inputs while busy
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 15)];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 15) == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      model(op, a, b, erc, elat, edbz);
      run_op(op, a, b, 1, rc, lat, dbz, ok);
      chk($sformatf("rnd%0d_op%b_rc", n, op), rc, erc);
      chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(elat));
      chk($sformatf("rnd%0d_dbz", n), {63'h0, dbz}, {63'h0, edbz});
      chk($sformatf("rnd%0d_busy", n), {63'h0, ok}, 64'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the width of the shift/rotate amount field taken from Rb.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port clear, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-006 Port opcode, input, 5 bits: operation select, sampled with start.
REQ-007 Ports Ra and Rb, inputs, WIDTH bits each: operands, sampled with start.
REQ-008 Port Rc, output, 2*WIDTH bits: registered result.
REQ-009 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 Port done, output, 1 bit: single-cycle pulse marking a valid Rc.
REQ-011 Port div_by_zero, output, 1 bit: high with done when a divide had Rb == 0.

Function
REQ-012 Opcodes SHALL be: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, mul 01110, div 01111, neg 10000, not 10001, shra 10010.
REQ-013 The state machine SHALL have states IDLE, CALC and DONE.
REQ-014 Transitions SHALL be: IDLE->DONE on start with a single-cycle op; IDLE->CALC on start with mul or div (Rb != 0); CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-015 Operands and opcode SHALL be latched on the start edge; later input changes SHALL NOT affect the result.
REQ-016 Single-cycle ops SHALL load Rc on the start edge, so done is high in the following cycle (latency 1).
REQ-017 For single-cycle ops, Rc[WIDTH-1:0] SHALL hold the result and Rc[2*WIDTH-1:WIDTH] SHALL be zero.
REQ-018 Add and sub SHALL be modulo 2^WIDTH with no carry reported; neg SHALL give 0-Ra; not SHALL give ~Ra.
REQ-019 Shifts and rotates SHALL use the amount Rb[SHW-1:0] and ignore the upper bits of Rb.
REQ-020 Shr and shl SHALL zero-fill, and shra SHALL replicate Ra[WIDTH-1].
REQ-021 Mul SHALL be signed radix-2 Booth, one iteration per CALC cycle, giving the full signed 2*WIDTH product in Rc.
REQ-022 Div SHALL be signed restoring division, one quotient bit per CALC cycle.
REQ-023 The div quotient SHALL truncate toward zero, and the remainder SHALL take the sign of Ra.
REQ-024 Div SHALL place the remainder in Rc[2*WIDTH-1:WIDTH] and the quotient in Rc[WIDTH-1:0].
REQ-025 Mul and div SHALL have done high exactly WIDTH cycles after the start edge, and busy high from the start edge until done falls.
REQ-026 Div with Rb == 0 SHALL take the single-cycle path, giving quotient all-ones, remainder Ra, and div_by_zero high for the done cycle.
REQ-027 Undefined opcodes SHALL complete in one cycle with Rc = 0.
REQ-028 Start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-029 Start in the DONE cycle SHALL be ignored; back-to-back issue is therefore one op per latency+1 cycles.
REQ-030 Rc SHALL hold its value until the next completed operation loads it.
REQ-031 Done and div_by_zero SHALL be low in every cycle except DONE.

Reset
REQ-032 Clear low SHALL immediately force state IDLE, Rc = 0, busy = 0, done = 0, div_by_zero = 0, and clear the iteration counter and internal accumulators.
REQ-033 Clear asserted mid-operation SHALL abort that operation; no done SHALL follow it.
REQ-034 After clear deasserts, the first start SHALL be accepted normally.

Verification (WIDTH = 32)
REQ-035 Add: Ra = FFFFFFF5, Rb = 2 -> one cycle later done = 1, Rc = 00000000_FFFFFFF7.
REQ-036 Shra and ror: Ra = FFFFFFF5, Rb = 2 -> shra Rc low half FFFFFFFD; ror Rc low half 7FFFFFFD; each with latency 1.
REQ-037 Mul: Ra = FFFFFFF5, Rb = 2 -> done exactly 32 cycles after start, Rc = FFFFFFFF_FFFFFFEA, busy high throughout.
REQ-038 Div: Ra = FFFFFFF5, Rb = 2 -> Rc = FFFFFFFF_FFFFFFFB (remainder -1, quotient -5) after 32 cycles; then Rb = 0 -> latency 1, div_by_zero = 1, Rc = FFFFFFF5_FFFFFFFF.
REQ-039 Start pulsed at cycle 5 of a mul -> ignored, mul result unchanged; clear pulsed at cycle 10 of a second mul -> all outputs 0, no done, and the next add completes correctly.
